// File: rtl/cart_types_pkg.sv
// Cartridge type package: type codes, the default bank width, and the
// window/bank state each type comes up in after selection.
package cart_types_pkg;

    localparam int BANK_W_DEF = 7;

    localparam logic [7:0] CART_OFF          = 8'h00;
    localparam logic [7:0] CART_STD_8K       = 8'h01;
    localparam logic [7:0] CART_STD_16K      = 8'h02;
    localparam logic [7:0] CART_XEGS_64K     = 8'h03;
    localparam logic [7:0] CART_WILLIAMS_64K = 8'h04;
    localparam logic [7:0] CART_ATARIMAX_1M  = 8'h05;
    localparam logic [7:0] CART_SDX_64K      = 8'h06;

    typedef struct packed {
        logic [BANK_W_DEF-1:0] bank;
        logic                  rd4;
        logic                  rd5;
    } cart_win_t;

    localparam cart_win_t DEF_OFF    = '{bank: '0, rd4: 1'b0, rd5: 1'b0};
    localparam cart_win_t DEF_8K     = '{bank: '0, rd4: 1'b0, rd5: 1'b1};
    localparam cart_win_t DEF_16K    = '{bank: '0, rd4: 1'b1, rd5: 1'b1};
    localparam cart_win_t DEF_XEGS   = '{bank: '0, rd4: 1'b1, rd5: 1'b1};
    localparam cart_win_t DEF_SWITCH = '{bank: '0, rd4: 1'b0, rd5: 1'b1};

    // Unknown codes fall back to OFF.
    function automatic cart_win_t type_default(input logic [7:0] t);
        case (t)
            CART_STD_8K:       return DEF_8K;
            CART_STD_16K:      return DEF_16K;
            CART_XEGS_64K:     return DEF_XEGS;
            CART_WILLIAMS_64K,
            CART_ATARIMAX_1M,
            CART_SDX_64K:      return DEF_SWITCH;
            default:           return DEF_OFF;
        endcase
    endfunction

endpackage

// File: rtl/cart_bus_sync.sv
// Atari bus front end: synchronizes the asynchronous bus signals, detects
// the PHI2 falling edge and snapshots the bus as it stood on the last
// synced PHI2-high cycle.
//   clk, reset           system clock, synchronous active-high reset
//   phi2..data           raw asynchronous Atari bus inputs
//   access_evt           one-cycle pulse: PHI2 fell and snapshot CCTL was low
//   acc_addr/data/rw     snapshot of the access that just ended
// SYNC_STAGES must be at least 2.
module cart_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi2,
    input  logic        cctl_n,
    input  logic        rw,
    input  logic [12:0] addr,
    input  logic [7:0]  data,
    output logic        access_evt,
    output logic [12:0] acc_addr,
    output logic [7:0]  acc_data,
    output logic        acc_rw
);

    localparam int W = 24;  // phi2, cctl_n, rw, addr[12:0], data[7:0]

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0] last;
    logic         phi2_s;
    logic         phi2_prev;
    logic         snap_cctl_n;

    assign last   = sync_q[SYNC_STAGES-1];
    assign phi2_s = last[23];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            phi2_prev   <= 1'b0;
            snap_cctl_n <= 1'b1;
            acc_rw      <= 1'b1;
            acc_addr    <= '0;
            acc_data    <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], {phi2, cctl_n, rw, addr, data}};
            phi2_prev <= phi2_s;
            // Keep refreshing while PHI2 is high so the value left behind is
            // the one from the final high cycle.
            if (phi2_s) begin
                snap_cctl_n <= last[22];
                acc_rw      <= last[21];
                acc_addr    <= last[20:8];
                acc_data    <= last[7:0];
            end
        end
    end

    assign access_evt = phi2_prev & ~phi2_s & ~snap_cctl_n;

endmodule

// File: rtl/cart_bank_ctrl.sv
// Cartridge bank-switch controller: tracks the host-selected cartridge type
// and applies that type's bank-switching rule to CCTL accesses.
//   clk, reset       system clock, synchronous active-high reset
//   cart_type        type code from the PIO register
//   bus_*            asynchronous Atari bus inputs
//   bank, rd4, rd5   registered bank number and window enables
//   bank_strobe      one-cycle pulse after {bank,rd4,rd5} changes
module cart_bank_ctrl
    import cart_types_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BANK_W      = BANK_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cart_type,
    input  logic              bus_phi2,
    input  logic              bus_cctl_n,
    input  logic              bus_rw,
    input  logic [12:0]       bus_addr,
    input  logic [7:0]        bus_data,
    output logic [BANK_W-1:0] bank,
    output logic              rd4,
    output logic              rd5,
    output logic              bank_strobe
);

    logic        access_evt;
    logic [12:0] acc_addr;
    logic [7:0]  acc_data;
    logic        acc_rw;

    cart_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .phi2       (bus_phi2),
        .cctl_n     (bus_cctl_n),
        .rw         (bus_rw),
        .addr       (bus_addr),
        .data       (bus_data),
        .access_evt (access_evt),
        .acc_addr   (acc_addr),
        .acc_data   (acc_data),
        .acc_rw     (acc_rw)
    );

    // No scheme decodes A12..A8 or the upper data bits.
    logic unused_bits;
    assign unused_bits = ^{acc_addr[12:8], acc_data[7:3]};

    logic [7:0]        type_q;
    logic              init_pend;  // forces a defaults load right after reset
    cart_win_t         dflt;
    logic [BANK_W-1:0] nxt_bank;
    logic              nxt_rd4;
    logic              nxt_rd5;

    assign dflt = type_default(cart_type);

    always_comb begin
        nxt_bank = bank;
        nxt_rd4  = rd4;
        nxt_rd5  = rd5;
        if (init_pend || cart_type != type_q) begin
            // Type change wins; a coincident access event is dropped.
            nxt_bank = BANK_W'(dflt.bank);
            nxt_rd4  = dflt.rd4;
            nxt_rd5  = dflt.rd5;
        end else if (access_evt) begin
            case (type_q)
                CART_XEGS_64K: begin
                    if (!acc_rw) nxt_bank = BANK_W'(acc_data[2:0]);
                end
                CART_WILLIAMS_64K: begin
                    if (acc_addr[7:4] == 4'h0) begin
                        if (acc_addr[3]) begin
                            nxt_rd5 = 1'b0;
                        end else begin
                            nxt_rd5  = 1'b1;
                            nxt_bank = BANK_W'(acc_addr[2:0]);
                        end
                    end
                end
                CART_ATARIMAX_1M: begin
                    if (acc_addr[7]) begin
                        nxt_rd5 = 1'b0;
                    end else begin
                        nxt_rd5  = 1'b1;
                        nxt_bank = BANK_W'(acc_addr[6:0]);
                    end
                end
                CART_SDX_64K: begin
                    if (acc_addr[7:4] == 4'hE) begin
                        if (acc_addr[3]) begin
                            nxt_rd5 = 1'b0;
                        end else begin
                            nxt_rd5  = 1'b1;
                            nxt_bank = BANK_W'(3'(~acc_addr[2:0]));
                        end
                    end
                end
                default: ;  // fixed-mapping and OFF types ignore accesses
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            type_q      <= CART_OFF;
            init_pend   <= 1'b1;
            bank        <= '0;
            rd4         <= 1'b0;
            rd5         <= 1'b0;
            bank_strobe <= 1'b0;
        end else begin
            type_q      <= cart_type;
            init_pend   <= 1'b0;
            bank        <= nxt_bank;
            rd4         <= nxt_rd4;
            rd5         <= nxt_rd5;
            bank_strobe <= ({nxt_bank, nxt_rd4, nxt_rd5} != {bank, rd4, rd5});
        end
    end

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Bench for cart_bank_ctrl: directed bus cycles, a behavioural model of the
// cartridge rules, a per-cycle compare process and literal spot checks.
module tb_cart_bank_ctrl;

    localparam int S  = 2;
    localparam int BW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    cart_type;
    logic          bus_phi2, bus_cctl_n, bus_rw;
    logic [12:0]   bus_addr;
    logic [7:0]    bus_data;
    logic [BW-1:0] bank;
    logic          rd4, rd5, bank_strobe;

    always #5 clk = ~clk;

    cart_bank_ctrl #(.SYNC_STAGES(S), .BANK_W(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cart_type   (cart_type),
        .bus_phi2    (bus_phi2),
        .bus_cctl_n  (bus_cctl_n),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_data    (bus_data),
        .bank        (bank),
        .rd4         (rd4),
        .rd5         (rd5),
        .bank_strobe (bank_strobe)
    );

    int tests = 0;
    int fails = 0;

    // Model state: what the outputs must read after the last effective edge.
    int m_bank = 0;
    int m_rd4 = 0, m_rd5 = 0, m_strobe = 0;
    int m_type = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_model(input int b, input int r4, input int r5);
        m_strobe = (b != m_bank || r4 != m_rd4 || r5 != m_rd5) ? 1 : 0;
        m_bank = b; m_rd4 = r4; m_rd5 = r5;
    endtask

    task automatic model_defaults(input int t);
        case (t)
            1:       set_model(0, 0, 1);
            2, 3:    set_model(0, 1, 1);
            4, 5, 6: set_model(0, 0, 1);
            default: set_model(0, 0, 0);
        endcase
    endtask

    task automatic model_event(input int a, input int d, input int rw);
        int lo, b, r4, r5;
        lo = a % 256; b = m_bank; r4 = m_rd4; r5 = m_rd5;
        case (m_type)
            3: if (rw == 0) b = d % 8;
            4: if (lo < 16) begin
                   if (lo >= 8) r5 = 0;
                   else begin r5 = 1; b = lo; end
               end
            5: if (lo >= 128) r5 = 0;
               else begin r5 = 1; b = lo; end
            6: if (lo / 16 == 14) begin
                   if (lo % 16 >= 8) r5 = 0;
                   else begin r5 = 1; b = 7 - (lo % 8); end
               end
            default: ;
        endcase
        set_model(b, r4, r5);
    endtask

    // A strobe lasts one cycle; any new change re-arms it after this clear.
    always @(posedge clk) begin
        #1 m_strobe = 0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("bank", int'(bank), m_bank);
            check("rd4", int'(rd4), m_rd4);
            check("rd5", int'(rd5), m_rd5);
            check("strobe", int'(bank_strobe), m_strobe);
        end
    end

    // All stimulus tasks start and end 3 time units after a rising edge.
    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic set_type(input int t);
        cart_type = 8'(t);
        @(posedge clk); #2;
        m_type = t;
        model_defaults(t);
        #1;
    endtask

    // One bus cycle. After PHI2 falls, the bus is scrambled so only the
    // snapshot can carry the access. new_type >= 0 lands a type change on
    // the same edge the fall is detected.
    task automatic access(input int a, input int d, input int rw,
                          input int cctl, input int new_type);
        bus_addr = 13'(a); bus_data = 8'(d); bus_rw = rw[0];
        bus_cctl_n = cctl[0]; bus_phi2 = 1'b1;
        repeat (S + 3) tick();
        bus_phi2 = 1'b0; bus_addr = 13'h1FFF; bus_data = 8'hFF;
        bus_rw = ~rw[0]; bus_cctl_n = 1'b1;
        repeat (S) @(posedge clk);
        #3;
        if (new_type >= 0) cart_type = 8'(new_type);
        @(posedge clk); #2;
        if (new_type >= 0) begin
            m_type = new_type;
            model_defaults(new_type);
        end else if (cctl == 0) begin
            model_event(a, d, rw);
        end
        #1;
        repeat (2) tick();
    endtask

    // Reset pulled in the middle of a CCTL write, PHI2 falling while held.
    task automatic reset_mid_access(input int a, input int d);
        bus_addr = 13'(a); bus_data = 8'(d); bus_rw = 1'b0;
        bus_cctl_n = 1'b0; bus_phi2 = 1'b1;
        repeat (S + 2) tick();
        chk_en = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_mid_bank", int'(bank), 0);
        check("rst_mid_rd5", int'(rd5), 0);
        check("rst_mid_strobe", int'(bank_strobe), 0);
        bus_phi2 = 1'b0;
        repeat (S + 2) tick();
        bus_cctl_n = 1'b1;
        reset = 1'b0;
        m_bank = 0; m_rd4 = 0; m_rd5 = 0; m_strobe = 0;
        m_type = int'(cart_type);
        chk_en = 1'b1;
        @(posedge clk); #2;
        model_defaults(m_type);
        #1;
        repeat (S + 3) tick();
    endtask

    initial begin
        reset = 1'b1; cart_type = 8'h00;
        bus_phi2 = 1'b0; bus_cctl_n = 1'b1; bus_rw = 1'b1;
        bus_addr = '0; bus_data = '0;
        repeat (3) tick();
        check("reset_bank", int'(bank), 0);
        check("reset_rd4", int'(rd4), 0);
        check("reset_rd5", int'(rd5), 0);
        check("reset_strobe", int'(bank_strobe), 0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #2; model_defaults(0); #1;
        tick();

        // STD_16K: both windows on, one strobe.
        set_type(2);
        check("16k_rd4", int'(rd4), 1);
        check("16k_rd5", int'(rd5), 1);
        check("16k_strobe", int'(bank_strobe), 1);
        tick();
        check("16k_strobe_once", int'(bank_strobe), 0);

        // XEGS: write selects bank, read and non-CCTL writes do nothing.
        set_type(3);
        access(13'h1500, 8'h05, 0, 0, -1);
        check("xegs_wr_bank", int'(bank), 5);
        access(13'h1500, 8'h07, 1, 0, -1);
        check("xegs_rd_bank", int'(bank), 5);
        access(13'h1500, 8'h06, 0, 1, -1);
        check("xegs_nocctl_bank", int'(bank), 5);

        // ATARIMAX: address selects bank, A7 disables, identical rewrite.
        set_type(5);
        access(13'h1533, 8'h00, 1, 0, -1);
        check("amax_bank", int'(bank), 8'h33);
        check("amax_rd5", int'(rd5), 1);
        access(13'h1580, 8'h00, 0, 0, -1);
        check("amax_off_rd5", int'(rd5), 0);
        check("amax_off_bank", int'(bank), 8'h33);
        access(13'h1533, 8'h00, 1, 0, -1);
        access(13'h1533, 8'h00, 1, 0, -1);
        access(13'h157F, 8'h00, 1, 0, -1);
        check("amax_top_bank", int'(bank), 127);

        // WILLIAMS.
        set_type(4);
        access(13'h1503, 8'h00, 1, 0, -1);
        check("will_bank", int'(bank), 3);
        access(13'h1508, 8'h00, 1, 0, -1);
        check("will_off_rd5", int'(rd5), 0);
        check("will_off_bank", int'(bank), 3);
        access(13'h1513, 8'h00, 1, 0, -1);
        check("will_ign_rd5", int'(rd5), 0);
        check("will_ign_bank", int'(bank), 3);
        access(13'h1506, 8'h00, 0, 0, -1);
        check("will_on_bank", int'(bank), 6);

        // SDX, then a type change landing on an event edge.
        set_type(6);
        access(13'h15E2, 8'h00, 1, 0, -1);
        check("sdx_bank", int'(bank), 5);
        check("sdx_rd5", int'(rd5), 1);
        access(13'h15EA, 8'h00, 1, 0, -1);
        check("sdx_off_rd5", int'(rd5), 0);
        access(13'h15E0, 8'h00, 1, 0, 1);
        check("drop_bank", int'(bank), 0);
        check("drop_rd4", int'(rd4), 0);
        check("drop_rd5", int'(rd5), 1);

        // Reset during an access with live state.
        set_type(5);
        access(13'h1533, 8'h00, 1, 0, -1);
        reset_mid_access(13'h1511, 8'h00);
        check("post_rst_bank", int'(bank), 0);
        check("post_rst_rd5", int'(rd5), 1);

        // Unsupported code behaves as OFF.
        set_type(7);
        check("unk_rd4", int'(rd4), 0);
        check("unk_rd5", int'(rd5), 0);
        access(13'h1500, 8'h03, 0, 0, -1);
        access(13'h1533, 8'h00, 1, 0, -1);
        check("unk_bank", int'(bank), 0);
        reset_mid_access(13'h1500, 8'h02);
        check("unk_rst_bank", int'(bank), 0);
        check("unk_rst_strobe", int'(bank_strobe), 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
